// File: rtl/syswb_keys_pio.sv
// Avalon-MM input PIO for push-buttons and switches.
// Each input bit is synchronised and debounced. Selected edges of the
// debounced value are captured per bit, and a masked level IRQ is raised
// from the capture register. The slave has zero wait states and read latency 0.
module syswb_keys_pio #(
  parameter int unsigned     WIDTH       = 4,
  parameter int unsigned     DEBOUNCE    = 16,
  parameter int unsigned     EDGE_TYPE   = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] data_prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] new_edges;
  logic             wr_mask, wr_ecap;
  logic             unused_wd;

  // The upper write-data bits are not used when WIDTH < 32.
  assign unused_wd = ^writedata;

  assign wr_mask = chipselect & ~write_n & (address == ADDR_IRQMASK);
  assign wr_ecap = chipselect & ~write_n & (address == ADDR_EDGECAP);

  // Per-bit debounce: data follows s2 only after DEBOUNCE consecutive differing samples.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == data_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        data_d[i] = s2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Edge selection on the debounced value.
  always_comb begin
    new_edges = '0;
    if (EDGE_TYPE == 0) begin
      new_edges = data_q & ~data_prev_q;
    end else if (EDGE_TYPE == 1) begin
      new_edges = ~data_q & data_prev_q;
    end else begin
      new_edges = data_q ^ data_prev_q;
    end
  end

  // Capture and mask updates; a new edge wins over a same-cycle clear.
  always_comb begin
    mask_d = mask_q;
    ecap_d = ecap_q | new_edges;
    if (wr_mask) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_ecap) begin
      ecap_d = (ecap_q & ~writedata[WIDTH-1:0]) | new_edges;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= RESET_VALUE;
      s2_q        <= RESET_VALUE;
      data_q      <= RESET_VALUE;
      data_prev_q <= RESET_VALUE;
      mask_q      <= '0;
      ecap_q      <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q        <= in_port;
      s2_q        <= s1_q;
      data_q      <= data_d;
      data_prev_q <= data_q;
      mask_q      <= mask_d;
      ecap_q      <= ecap_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Zero-latency read mux; DIRECTION and unused bits read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(data_q);
      ADDR_IRQMASK: readdata = 32'(mask_q);
      ADDR_EDGECAP: readdata = 32'(ecap_q);
      default:      readdata = '0;
    endcase
  end

  // Level interrupt straight from the registers.
  assign irq = |(ecap_q & mask_q);

endmodule
